// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the instruction fetch front end
package instr_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam int PC_STEP = 4;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [PC_W-1:0] pc_t;
  typedef struct packed {
    pc_t pc;
    instr_t instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries; flush wins over push.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o,
  output logic         empty_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= entry_i;
        wr_q <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, BRAM reader and valid/ready front end with branch flush.
// Optional perf counters when IFETCH_PERF_CNT_EN is defined.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 10,
  parameter int  INSTR_WIDTH = INSTR_W,
  parameter int  PC_WIDTH    = PC_W,
  parameter pc_t RESET_PC    = '0,
  parameter int  FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_di,
  input  logic [INSTR_WIDTH-1:0] mem_dout,
  input  logic                   br_taken,
  input  logic [PC_WIDTH-1:0]    br_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  pc_t pc_q, pc_d, inflight_pc_q;
  logic inflight_q, pop, push, empty;
  logic [CW-1:0] count;
  logic [CW:0] used;
  fetch_entry_t head, entry;
  // Credits: buffered + inflight entries after this cycle's pop must fit.
  assign used = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign out_valid = !reset & !empty;
  assign pop = out_valid & out_ready;
  assign mem_en = !reset & !br_taken & (used < (CW + 1)'(FIFO_DEPTH));
  assign push = inflight_q & !br_taken;
  assign pc_d = br_taken ? (br_target & ~pc_t'(3)) : mem_en ? pc_q + pc_t'(PC_STEP) : pc_q;
  assign entry = '{pc: inflight_pc_q, instr: mem_dout};
  assign mem_we = 1'b0;
  assign mem_di = '0;
  assign mem_addr = pc_q[ADDR_WIDTH+1:2];
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc = out_valid ? head.pc : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= mem_en;
      if (mem_en) inflight_pc_q <= pc_q;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .flush_i (br_taken),
    .count_o (count),
    .head_o  (head),
    .empty_o (empty)
  );
  assert property (@(posedge clk) disable iff (reset) push |-> count < CW'(FIFO_DEPTH));
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(pop);
      stall_cnt_q <= stall_cnt_q + 32'(out_valid & !out_ready);
      flush_cnt_q <= flush_cnt_q + 32'(br_taken);
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch; perf counters checked when IFETCH_PERF_CNT_EN is defined.
module tb_instr_fetch;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_en, mem_we, br_taken = 1'b0, out_valid, out_ready = 1'b1;
  logic [9:0] mem_addr;
  logic [31:0] mem_di, mem_dout = '0, br_target = '0, out_instr, out_pc;
  logic [63:0] exp_q [$];
  int vectors = 0, fails = 0, n_xfer = 0, n_stall = 0, n_flush = 0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif
  instr_fetch dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_di(mem_di), .mem_dout(mem_dout), .br_taken(br_taken), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  // BRAM model, no-change mode: word k holds 'hA000+k
  always @(posedge clk) if (mem_en) mem_dout <= 32'hA000 + {22'b0, mem_addr};
  function automatic void push_from(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, 32'hA000 + {22'b0, pc[11:2]}});
      pc = pc + 32'd4;
    end
  endfunction
  always @(negedge clk) begin
    logic [63:0] e;
    if (out_valid && out_ready) begin
      n_xfer++;
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL xfer_unexpected got pc=%h instr=%h, none expected", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          fails++;
          $display("FAIL xfer got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
    if (out_valid && !out_ready) n_stall++;
    if (br_taken && !reset) n_flush++;
  end
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors += 4;
    if (out_valid !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got valid=%b en=%b want 0 0", out_valid, mem_en);
    end
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got pc=%h instr=%h want 0 0", out_pc, out_instr);
    end
    if (mem_we !== 1'b0) begin fails++; $display("FAIL mem_we got %b want 0", mem_we); end
    if (mem_di !== 32'h0) begin fails++; $display("FAIL mem_di got %h want 0", mem_di); end
    push_from(32'h0, 64);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== (c == 2)) begin
        fails++;
        $display("FAIL latency cycle %0d got valid=%b want %b", c, out_valid, c == 2);
      end
      if (c == 0) begin
        vectors++;
        if (mem_en !== 1'b1 || mem_addr !== 10'd0) begin
          fails++;
          $display("FAIL first_issue got en=%b addr=%h want 1 0", mem_en, mem_addr);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || mem_en !== 1'b0 || {out_pc, out_instr} !== exp_q[0]) begin
        fails++;
        $display("FAIL stall %0d got valid=%b en=%b pc=%h instr=%h want 1 0 %h %h",
                 i, out_valid, mem_en, out_pc, out_instr, exp_q[0][63:32], exp_q[0][31:0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  task automatic test_redirect();
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    br_taken = 1'b1;
    br_target = 32'h103;
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b0) begin fails++; $display("FAIL redirect_no_issue got en=%b want 0", mem_en); end
    @(posedge clk); #1;
    br_taken = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    push_from(32'h100, 64);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== (c == 3)) begin
        fails++;
        $display("FAIL redirect_latency N+%0d got valid=%b want %b", c, out_valid, c == 3);
      end
      if (c == 1) begin
        vectors++;
        if (mem_en !== 1'b1 || mem_addr !== 10'h40) begin
          fails++;
          $display("FAIL redirect_issue got en=%b addr=%h want 1 040", mem_en, mem_addr);
        end
      end
    end
    vectors++;
    if (out_pc !== 32'h100 || out_instr !== 32'hA040) begin
      fails++;
      $display("FAIL redirect_first got pc=%h instr=%h want 100 a040", out_pc, out_instr);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    @(posedge clk); #1;
    br_taken = 1'b1;
    br_target = 32'h20;
    @(posedge clk); #1;
    br_target = 32'h40;
    exp_q.delete();
    push_from(32'h40, 64);
    @(posedge clk); #1;
    br_taken = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== (c == 4)) begin
        fails++;
        $display("FAIL b2b_latency N+%0d got valid=%b want %b", c, out_valid, c == 4);
      end
    end
    vectors++;
    if (out_pc !== 32'h40) begin fails++; $display("FAIL b2b_first got pc=%h want 40", out_pc); end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_wrap();
    logic [9:0] want_addr [3];
    want_addr[0] = 10'd1022;
    want_addr[1] = 10'd1023;
    want_addr[2] = 10'd0;
    @(posedge clk); #1;
    br_taken = 1'b1;
    br_target = 32'hFF8;
    @(posedge clk); #1;
    br_taken = 1'b0;
    exp_q.delete();
    push_from(32'hFF8, 32);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (mem_en !== 1'b1 || mem_addr !== want_addr[c]) begin
        fails++;
        $display("FAIL wrap_addr N+%0d got en=%b addr=%0d want 1 %0d", c + 1, mem_en, mem_addr, want_addr[c]);
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFF8) begin
      fails++;
      $display("FAIL wrap_first got valid=%b pc=%h want 1 ff8", out_valid, out_pc);
    end
    repeat (5) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    @(posedge clk); #1;
`ifdef IFETCH_PERF_CNT_EN
    vectors++;
    if (perf_fetch_cnt !== 32'(n_xfer) || perf_stall_cnt !== 32'(n_stall) || perf_flush_cnt !== 32'(n_flush)) begin
      fails++;
      $display("FAIL perf_counts got %0d/%0d/%0d want %0d/%0d/%0d", perf_fetch_cnt, perf_stall_cnt,
               perf_flush_cnt, n_xfer, n_stall, n_flush);
    end
`endif
    reset = 1'b1;
    n_xfer = 0;
    n_stall = 0;
    n_flush = 0;
    exp_q.delete();
    push_from(32'h0, 64);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL midreset_hold got valid=%b en=%b want 0 0", out_valid, mem_en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== (c == 3)) begin
        fails++;
        $display("FAIL midreset_latency R+%0d got valid=%b want %b", c, out_valid, c == 3);
      end
      if (c == 1) begin
        vectors++;
        if (mem_en !== 1'b1 || mem_addr !== 10'd0) begin
          fails++;
          $display("FAIL midreset_issue got en=%b addr=%h want 1 0", mem_en, mem_addr);
        end
`ifdef IFETCH_PERF_CNT_EN
        vectors++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
          fails++;
          $display("FAIL perf_zero got %0d/%0d/%0d want 0/0/0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
`endif
      end
    end
    vectors++;
    if (out_pc !== 32'h0 || out_instr !== 32'hA000) begin
      fails++;
      $display("FAIL midreset_first got pc=%h instr=%h want 0 a000", out_pc, out_instr);
    end
    repeat (4) @(negedge clk);
`ifdef IFETCH_PERF_CNT_EN
    @(posedge clk); #1;
    vectors++;
    if (perf_fetch_cnt !== 32'(n_xfer)) begin
      fails++;
      $display("FAIL perf_fetch_after got %0d want %0d", perf_fetch_cnt, n_xfer);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
